// File: rtl/aes_final_round.sv
// AES round 10 (SubBytes via the shared S-box slice, ShiftRows, AddRoundKey) with a 2-entry output FIFO.
// One cycle from accept to FIFO push when key_valid is high; accepts new blocks only while the FIFO has room.
module aes_final_round #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] round_key,
  input  logic         key_valid,
  input  logic [127:0] in_block,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] old_sbox,
  input  logic [127:0] new_sbox,
  output logic [127:0] out_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic {IDLE, SUB} state_t;

  state_t       r_state;
  logic [127:0] r_data;
  logic [127:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  state_t       w_state_nxt;
  logic [127:0] w_shift;
  logic [127:0] w_result;
  logic         w_accept;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count_nxt;

  // Byte i sits at bits [127-8i -: 8]; row r of column c is byte 4c+r.
  always_comb begin
    w_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shift[127-8*(4*c+r) -: 8] = new_sbox[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  assign w_result    = w_shift ^ round_key;
  assign w_accept    = in_valid & r_in_ready;
  assign w_push      = (r_state == SUB) & key_valid;
  assign w_pop       = out_ready & r_out_valid;
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SUB;
      SUB:     if (key_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from next-state values so they are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_data <= in_block;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_result;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_state_nxt == IDLE) && (w_count_nxt < 2'(FIFO_DEPTH));
      r_out_valid <= (w_count_nxt != 2'd0);
      r_busy      <= (w_state_nxt == SUB) || (w_count_nxt != 2'd0);
    end
  end

  assign old_sbox  = r_data;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_block = r_out_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_aes_final_round.sv
// Bench for aes_final_round: provides the S-box slice and checks against a byte-matrix round-10 model.
module tb_aes_final_round;

  logic         clk;
  logic         reset_n;
  logic [127:0] round_key;
  logic         key_valid;
  logic [127:0] in_block;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] old_sbox;
  logic [127:0] new_sbox;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  aes_final_round #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .round_key (round_key),
    .key_valid (key_valid),
    .in_block  (in_block),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .old_sbox  (old_sbox),
    .new_sbox  (new_sbox),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sbox_tab [256];

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign new_sbox[127-8*g -: 8] = sbox_tab[old_sbox[127-8*g -: 8]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] FIPS_IN  = 128'heb40f21e_592e3884_8ba113e7_1bc342d2;
  localparam logic [127:0] FIPS_KEY = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] FIPS_OUT = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  typedef struct {
    logic [127:0] blk;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [12];
  logic [127:0] exp_q [$];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] blk, input logic [127:0] key);
    logic [7:0]   st [4][4];
    logic [7:0]   kk [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        st[r][c] = blk[127-8*(4*c+r) -: 8];
        kk[r][c] = key[127-8*(4*c+r) -: 8];
      end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = sbox_tab[st[r][(c+r)%4]] ^ kk[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_blk(input logic [127:0] b);
    int g;
    in_block = b;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk_bit("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int g;
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid) chk_bit("output_timeout", out_valid, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_bit({tag, "_in_ready"}, in_ready, 1'b0);
    chk_bit({tag, "_out_valid"}, out_valid, 1'b0);
    chk_bit({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_out_block"}, out_block, 128'h0);
    chk({tag, "_old_sbox"}, old_sbox, 128'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the test finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b, c, d, e, f, key;
    logic         acc_pending;
    int           g;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    key_valid = 1'b0;
    round_key = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    // Reset state and first-edge in_ready
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_bit("ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    chk_bit("ready_after_edge", in_ready, 1'b1);

    // App. B vector with latency observation
    round_key = FIPS_KEY;
    key_valid = 1'b1;
    push_blk(FIPS_IN);
    chk_bit("fips_valid_n", out_valid, 1'b0);
    chk_bit("fips_busy_n", busy, 1'b1);
    chk_bit("fips_ready_n", in_ready, 1'b0);
    chk("fips_state", old_sbox, FIPS_IN);
    step();
    chk_bit("fips_valid_n1", out_valid, 1'b1);
    chk("fips_data", out_block, FIPS_OUT);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_bit("fips_popped", out_valid, 1'b0);
    chk_bit("fips_idle", busy, 1'b0);

    // Table-driven vectors
    vecs[0] = '{FIPS_IN, FIPS_KEY, FIPS_OUT};
    vecs[1] = '{128'h0, 128'h0, {16{8'h63}}};
    for (int i = 2; i < 12; i++) begin
      a = rnd128();
      key = rnd128();
      vecs[i] = '{a, key, ref_round(a, key)};
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      round_key = vecs[i].key;
      push_blk(vecs[i].blk);
      wait_out();
      chk($sformatf("table_%0d", i), out_block, vecs[i].exp);
    end
    step();
    out_ready = 1'b0;

    // Backpressure: fill both entries, third block held until a pop
    key = rnd128();
    round_key = key;
    a = rnd128(); b = rnd128(); c = rnd128();
    push_blk(a);
    push_blk(b);
    step();
    chk_bit("bp_full_ready", in_ready, 1'b0);
    chk_bit("bp_full_valid", out_valid, 1'b1);
    chk("bp_head_a", out_block, ref_round(a, key));
    in_block = c;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bit($sformatf("bp_hold_ready_%0d", i), in_ready, 1'b0);
      chk($sformatf("bp_no_capture_%0d", i), old_sbox, b);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_bit("bp_ready_after_pop", in_ready, 1'b1);
    chk("bp_head_b", out_block, ref_round(b, key));
    step();
    in_valid = 1'b0;
    chk_bit("bp_c_accepted", in_ready, 1'b0);
    chk("bp_c_state", old_sbox, c);
    step();
    chk("bp_head_b_again", out_block, ref_round(b, key));
    out_ready = 1'b1;
    step();
    chk("bp_head_c", out_block, ref_round(c, key));
    step();
    out_ready = 1'b0;
    chk_bit("bp_drained", out_valid, 1'b0);

    // Key stall
    d = rnd128();
    key_valid = 1'b0;
    push_blk(d);
    for (int i = 0; i < 5; i++) begin
      chk_bit($sformatf("stall_busy_%0d", i), busy, 1'b1);
      chk_bit($sformatf("stall_valid_%0d", i), out_valid, 1'b0);
      chk($sformatf("stall_state_%0d", i), old_sbox, d);
      step();
    end
    key_valid = 1'b1;
    step();
    chk_bit("stall_done_valid", out_valid, 1'b1);
    chk("stall_done_data", out_block, ref_round(d, key));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Push and pop on the same edge with one entry held
    e = rnd128(); f = rnd128();
    push_blk(e);
    step();
    chk("pp_head_e", out_block, ref_round(e, key));
    push_blk(f);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_bit("pp_valid", out_valid, 1'b1);
    chk("pp_head_f", out_block, ref_round(f, key));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_bit("pp_count_one", out_valid, 1'b0);

    // Randomized stream against a queue of model results
    key = rnd128();
    round_key = key;
    acc_pending = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (acc_pending) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 1) == 1) begin
        in_block = rnd128();
        in_valid = 1'b1;
      end
      key_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc_pending = in_valid && in_ready;
      if (acc_pending) exp_q.push_back(ref_round(in_block, key));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk_bit("stream_spurious", out_valid, 1'b0);
        else chk("stream_data", out_block, exp_q.pop_front());
      end
    end
    g = 0;
    do begin
      @(negedge clk);
      in_valid  = 1'b0;
      key_valid = 1'b1;
      out_ready = 1'b1;
      if (out_valid) begin
        if (exp_q.size() == 0) chk_bit("drain_spurious", out_valid, 1'b0);
        else chk("drain_data", out_block, exp_q.pop_front());
      end
      g++;
    end while ((busy || exp_q.size() != 0) && g < 50);
    chk_bit("stream_all_out", exp_q.size() == 0, 1'b1);
    chk_bit("stream_idle", busy, 1'b0);
    out_ready = 1'b0;

    // Asynchronous reset while in SUB with an entry buffered
    a = rnd128(); b = rnd128();
    key_valid = 1'b1;
    push_blk(a);
    step();
    key_valid = 1'b0;
    push_blk(b);
    chk_bit("pre_reset_busy", busy, 1'b1);
    chk_bit("pre_reset_valid", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk_bit("post_reset_ready", in_ready, 1'b1);
    chk_bit("post_reset_empty", out_valid, 1'b0);
    round_key = FIPS_KEY;
    key_valid = 1'b1;
    push_blk(FIPS_IN);
    wait_out();
    chk("post_reset_fips", out_block, FIPS_OUT);
    out_ready = 1'b1;
    step();
    chk_bit("post_reset_drained", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
